// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param: master drives requests, slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 140,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              fifo_w_enable;
  logic [DATA_W-1:0] data_to_fifo;
  logic              fifo_r_enable;
  logic              err_clr;
  logic [DATA_W-1:0] data_from_fifo;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_almost_full;
  logic              fifo_almost_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_overflow;
  logic              fifo_underflow;

  modport master (
    output fifo_w_enable, data_to_fifo, fifo_r_enable, err_clr,
    input  data_from_fifo, fifo_empty, fifo_full, fifo_almost_full, fifo_almost_empty,
    input  fifo_count, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  fifo_w_enable, data_to_fifo, fifo_r_enable, err_clr,
    output data_from_fifo, fifo_empty, fifo_full, fifo_almost_full, fifo_almost_empty,
    output fifo_count, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 140,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input logic             clk_in,
  input logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_count;
  logic              r_empty, r_full, r_af, r_ae, r_ovf, r_udf;

  logic              w_wr_ok, w_rd_ok, w_ovf_set, w_udf_set;
  logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;

  always_comb begin
    // An empty FIFO is never readable, even with a same-cycle write.
    w_rd_ok      = bus.fifo_r_enable && !r_empty;
    w_wr_ok      = bus.fifo_w_enable && (!r_full || w_rd_ok);
    w_ovf_set    = bus.fifo_w_enable && r_full && !w_rd_ok;
    w_udf_set    = bus.fifo_r_enable && r_empty;
    w_wr_ptr_nxt = w_wr_ok ? r_wr_ptr + PW'(1) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_ok ? r_rd_ptr + PW'(1) : r_rd_ptr;
    w_count_nxt  = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + PW'(1);
      2'b01:   w_count_nxt = r_count - PW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      // Full: same index, opposite wrap bit.
      r_full   <= (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                  (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
      r_af     <= (w_count_nxt >= AF_LVL);
      r_ae     <= (w_count_nxt <= AE_LVL);
      r_ovf    <= w_ovf_set || (r_ovf && !bus.err_clr);
      r_udf    <= w_udf_set || (r_udf && !bus.err_clr);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.data_to_fifo;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_from_fifo = r_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
`else
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rd_ok) begin
      r_dout <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign bus.data_from_fifo = r_dout;
`endif

  assign bus.fifo_empty        = r_empty;
  assign bus.fifo_full         = r_full;
  assign bus.fifo_almost_full  = r_af;
  assign bus.fifo_almost_empty = r_ae;
  assign bus.fifo_count        = r_count;
  assign bus.fifo_overflow     = r_ovf;
  assign bus.fifo_underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench for sync_fifo_param (honours SYNC_FIFO_FWFT_EN when defined).
module tb_sync_fifo_param;
  localparam int unsigned DATA_W = 140;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF_T   = 14;
  localparam int unsigned AE_T   = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF_T),
    .AE_THRESH(AE_T)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int                checks   = 0;
  int                failures = 0;
  int                m_count  = 0;
  logic              m_ovf    = 1'b0;
  logic              m_udf    = 1'b0;
  logic [DATA_W-1:0] m_dout   = '0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    logic [DATA_W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("count", DATA_W'(bus.fifo_count), DATA_W'(m_count));
    chk("empty", DATA_W'(bus.fifo_empty), DATA_W'(m_count == 0));
    chk("full", DATA_W'(bus.fifo_full), DATA_W'(m_count == DEPTH));
    chk("almost_full", DATA_W'(bus.fifo_almost_full), DATA_W'(m_count >= AF_T));
    chk("almost_empty", DATA_W'(bus.fifo_almost_empty), DATA_W'(m_count <= AE_T));
    chk("overflow", DATA_W'(bus.fifo_overflow), DATA_W'(m_ovf));
    chk("underflow", DATA_W'(bus.fifo_underflow), DATA_W'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_data", bus.data_from_fifo, (m_count == 0) ? '0 : head);
`else
    chk("data_hold_or_read", bus.data_from_fifo, m_dout);
`endif
  endtask

  // One clock: drive inputs, predict acceptance from the model, check after the edge.
  task automatic cycle(input logic we, input logic [DATA_W-1:0] wd, input logic re,
                       input logic ec);
    bit rd_ok, wr_ok;
    int old_count;
    bus.fifo_w_enable = we;
    bus.data_to_fifo  = wd;
    bus.fifo_r_enable = re;
    bus.err_clr       = ec;
    old_count = m_count;
    rd_ok = re && (old_count > 0);
    wr_ok = we && ((old_count < DEPTH) || rd_ok);
`ifdef SYNC_FIFO_FWFT_EN
    if (rd_ok) chk("fwft_head_before_ack", bus.data_from_fifo, exp_q[0]);
`endif
    @(posedge clk_in);
    #1;
    if (rd_ok) m_dout = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(wd);
    m_count = old_count + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    m_ovf = (we && (old_count == DEPTH) && !rd_ok) || (m_ovf && !ec);
    m_udf = (re && (old_count == 0)) || (m_udf && !ec);
    bus.fifo_w_enable = 1'b0;
    bus.fifo_r_enable = 1'b0;
    bus.err_clr       = 1'b0;
    chk_status();
  endtask

  // Assert reset between edges and check that state clears without waiting for a clock.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_dout  = '0;
    chk("rst_data", bus.data_from_fifo, '0);
    chk_status();
    bus.fifo_w_enable = 1'b0;
    bus.fifo_r_enable = 1'b0;
    #9;
    rst = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.fifo_w_enable = 1'b0;
    bus.data_to_fifo  = '0;
    bus.fifo_r_enable = 1'b0;
    bus.err_clr       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("reset_data", bus.data_from_fifo, '0);
    chk_status();
    @(posedge clk_in);
    #3;
    rst = 1'b0;
    @(posedge clk_in);
    #1;

    // Fill to full; almost_full from count 14.
    for (int i = 1; i <= 16; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);

    // Dropped write while full.
    cycle(1'b1, DATA_W'('hDEAD), 1'b0, 1'b0);

    // Drain in order; 0xDEAD must never appear.
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Underflow from empty, then clear both sticky flags.
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Set-wins-over-clear on the same edge.
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous read and write across pointer wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'('h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, DATA_W'('h200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Mid-burst reset with a write in flight and underflow pending.
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'('h300 + i), 1'b0, 1'b0);
    bus.fifo_w_enable = 1'b1;
    bus.data_to_fifo  = DATA_W'('h3FF);
    async_reset();
    chk_status();

    // Short traffic after reset to show the FIFO is usable again.
    cycle(1'b1, DATA_W'('hA5), 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_first_word", bus.data_from_fifo, DATA_W'('hA5));
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("a5_read", bus.data_from_fifo,
`ifdef SYNC_FIFO_FWFT_EN
        '0
`else
        DATA_W'('hA5)
`endif
    );

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock successor to the design's 140-bit data FIFO. Adds generic width and depth, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Sits between the datapath producer and consumer stages that share one clock domain. An optional first-word-fall-through (FWFT) read mode is available.

Parameters:
- DATA_W, 140: data width in bits.
- DEPTH, 16: number of entries; must be a power of 2 and at least 2.
- AF_THRESH, 14: fifo_almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: fifo_almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk_in  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_w_enable  input  1  write request.
- data_to_fifo  input  DATA_W  write data.
- fifo_r_enable  input  1  read request.
- err_clr  input  1  synchronous clear of sticky error flags.
- data_from_fifo  output  DATA_W  read data.
- fifo_empty  output  1  count == 0.
- fifo_full  output  1  count == DEPTH.
- fifo_almost_full  output  1  count >= AF_THRESH.
- fifo_almost_empty  output  1  count <= AE_THRESH.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- fifo_overflow  output  1  sticky: a write was dropped.
- fifo_underflow  output  1  sticky: a read was dropped.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert inside the block):
  - Pointers = 0, fifo_count = 0, data_from_fifo = 0.
  - fifo_empty = 1, fifo_full = 0, fifo_almost_empty = 1, fifo_almost_full = 0 (AF_THRESH >= 1).
  - fifo_overflow = 0, fifo_underflow = 0.
  - Storage contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits with an extra wrap bit. Empty: pointers fully equal. Full: index bits equal and wrap bits differ. Pointer wrap from DEPTH-1 to 0 toggles the wrap bit.
- Write accept: wr_ok = fifo_w_enable && (!fifo_full || rd_ok).
- Read accept: rd_ok = fifo_r_enable && !fifo_empty. A write in the same cycle does not make an empty FIFO readable.
- Count update each edge: +1 if wr_ok only, -1 if rd_ok only, unchanged if both or neither.
- All flags and fifo_count are registered and reflect state after the current edge. They are never combinational from the enables.
- Standard read mode:
  - On rd_ok, data_from_fifo loads mem[rd_ptr] at the edge, giving one-cycle read latency.
  - data_from_fifo holds its value when rd_ok = 0.
  - A read of an entry written in the same cycle is impossible, because the FIFO cannot be empty and reading.
- Full plus simultaneous read and write: both accepted, count stays DEPTH, fifo_full stays 1.
- Overflow: set when fifo_w_enable && fifo_full && !rd_ok. Data is dropped and state is unchanged.
- Underflow: set when fifo_r_enable && fifo_empty. data_from_fifo holds its value.
- Sticky error flags clear on err_clr. If a set condition and err_clr occur in the same cycle, set wins.
- Reset asserted mid-burst: all state returns immediately to reset values, and any in-flight write is lost.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (FWFT mode):
  - data_from_fifo always shows mem[rd_ptr] combinationally when fifo_empty = 0. It shows 0 when empty.
  - fifo_r_enable acts as an acknowledge that pops the head entry.
  - The first written word appears on data_from_fifo the cycle after the write edge, when fifo_empty falls. No read is required.
- Undefined: standard registered-read mode as described above.
- Flags, count and error behaviour are identical in both modes.

Test Plan:
- Reset, then write 16 words 0x1..0x10 with no reads (DEPTH=16) -> fifo_count=16, fifo_full=1, fifo_almost_full=1 from count 14, fifo_overflow=0.
- From full, issue one extra write of 0xDEAD -> fifo_overflow=1, count stays 16. Then read 16 words -> outputs 0x1..0x10 in order, one cycle after each read, and 0xDEAD never appears.
- From empty, pulse fifo_r_enable -> fifo_underflow=1 and data_from_fifo unchanged. Pulse err_clr -> fifo_underflow=0 on the next edge.
- From full, assert read and write together for 20 cycles -> fifo_full stays 1, count stays 16, and the read stream is in order across pointer wrap.
- Write 8 words, then assert rst for 1 cycle mid-burst -> immediately fifo_count=0, fifo_empty=1, data_from_fifo=0, both error flags=0.
- With SYNC_FIFO_FWFT_EN defined, write 0xA5 once -> the next cycle fifo_empty=0 and data_from_fifo=0xA5 with no read. Pulse fifo_r_enable -> fifo_empty=1 and data_from_fifo=0.
